cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Micro-sequencer for the 8-bit CPU.
- Holds the per-instruction cycle counter, clocked by the cycle clock.
- Decodes the instruction-register opcode together with the current cycle into a one-of-N state code.
- The datapath derives every control strobe from that state code; the datapath asserts reset_cycle when it sees state NEXT, which starts the next instruction.

Parameters:
- STATE_W, 8, width of the state output.
- CYCLE_W, 4, width of the cycle counter.

Ports:
- clk  input  1  cycle clock; counter updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  8  instruction register contents; must be stable from cycle 2 onward.
- reset_cycle  input  1  synchronous request to restart the sequence at cycle 0.
- cycle  output  CYCLE_W  current micro-cycle index.
- state  output  STATE_W  decoded micro-state, combinational from cycle and opcode.
- illegal  output  1  undefined-opcode flag; see Optional Feature.

Behaviour:
- State codes:
  - NEXT=0, FETCH_PC=1, FETCH_INST=2, HALT=3, JUMP=4, OUT_A=5, ALU_OP=6.
  - MOV_FETCH=7, MOV_LOAD=8, MOV_STORE=9, LDI=10, TMP_STORE=11, FETCH_SP=12.
  - PC_STORE=13, TMP_JUMP=14, RET=15, INC_SP=16.
- Reset low: cycle=0 immediately, so state=FETCH_PC. Reset overrides reset_cycle.
- On each rising clk edge, the first matching rule applies:
  1. reset_cycle=1: cycle<=0.
  2. state==HALT: cycle holds.
  3. Otherwise: cycle<=cycle+1, wrapping at 2^CYCLE_W to 0.
- Cycle 0 is always FETCH_PC. Cycle 1 is always FETCH_INST, independent of opcode.
- From cycle 2 onward, the state is decoded from the opcode. Fields: op1=opcode[5:3], op2=opcode[2:0].
  - 0x00 NOP: NEXT.
  - 0x01 HLT: HALT for every cycle >=2.
  - 0x02 OUT: OUT_A, NEXT.
  - 00_010_rrr LDI: FETCH_PC, LDI, NEXT.
  - 0x18 JMP, 0x19 JEZ, 0x1A JNZ: FETCH_PC, JUMP, NEXT.
  - 0x1B CALL: FETCH_PC, TMP_STORE, FETCH_SP, PC_STORE, TMP_JUMP, NEXT.
  - 0x1C RET: INC_SP, FETCH_SP, RET, NEXT.
  - 01_ddd_sss MOV: MOV_FETCH, MOV_LOAD, MOV_STORE, NEXT.
  - 10_mmm_000 ALU: ALU_OP, NEXT.
  - Any other opcode is undefined and decodes as NOP (NEXT at cycle 2).
- Any cycle beyond the last listed state of a sequence decodes to NEXT.
- Cycle 1 decodes to FETCH_INST even while opcode is still changing.
- state is purely combinational. It changes only when cycle or opcode changes, and has no extra register latency.
- Upper state bits beyond bit 4 are always 0.
- Reset asserted mid-sequence: sequence aborts and cycle=0 at once. Deassertion resumes from FETCH_PC on the next edge.
- reset_cycle asserted in a non-NEXT state is still honoured (abort to cycle 0).
- illegal is 0 when the macro below is undefined.

Optional Feature:
- Macro CPU_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode decodes to HALT at cycle >=2.
  - illegal=1 whenever cycle>=2 and the opcode is undefined.
  - The counter freezes as for HLT.
- Undefined: undefined opcodes behave as NOP and illegal is tied 0.

Test Plan:
- Reset low with cycle=5 -> cycle=0 and state=1 without waiting for a clock edge. Release, then 2 edges with opcode=0x02 -> state sequence 1,2,5, then state=0 at cycle 3.
- opcode=0x1B (CALL), reset_cycle tied to (state==0) -> states 1,2,1,11,12,13,14,0 across cycles 0..7, then cycle returns to 0.
- opcode=0x4F (MOV a,mem) -> states 1,2,7,8,9,0; opcode=0x90 (ALU mode 2) -> 1,2,6,0.
- opcode=0x01 -> state=3 from cycle 2; 10 further edges leave cycle=2 and state=3; reset low returns cycle=0.
- opcode=0xFF with macro undefined -> state 0 at cycle 2 and illegal=0. With CPU_SEQ_ILLEGAL_TRAP_EN -> state 3, illegal=1, cycle frozen at 2.
- reset_cycle=1 at cycle 3 of a CALL -> cycle=0 after the edge; reset_cycle never asserted -> cycle wraps 15->0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Micro-sequencer: per-instruction cycle counter plus opcode/cycle decode to a one-of-N state code.
// Optional CPU_SEQ_ILLEGAL_TRAP_EN: undefined opcodes halt the sequence and raise illegal.
module cpu_sequencer #(
    parameter int STATE_W = 8,
    parameter int CYCLE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         opcode,
    input  logic               reset_cycle,
    output logic [CYCLE_W-1:0] cycle,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    typedef enum logic [4:0] {
        S_NEXT       = 5'd0,
        S_FETCH_PC   = 5'd1,
        S_FETCH_INST = 5'd2,
        S_HALT       = 5'd3,
        S_JUMP       = 5'd4,
        S_OUT_A      = 5'd5,
        S_ALU_OP     = 5'd6,
        S_MOV_FETCH  = 5'd7,
        S_MOV_LOAD   = 5'd8,
        S_MOV_STORE  = 5'd9,
        S_LDI        = 5'd10,
        S_TMP_STORE  = 5'd11,
        S_FETCH_SP   = 5'd12,
        S_PC_STORE   = 5'd13,
        S_TMP_JUMP   = 5'd14,
        S_RET        = 5'd15,
        S_INC_SP     = 5'd16
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_HLT, C_OUT, C_LDI, C_JMP, C_CALL, C_RET, C_MOV, C_ALU, C_UND
    } op_class_t;

    op_class_t cls;
    state_t    cur;
    logic      past_fetch;

    assign past_fetch = (cycle > CYCLE_W'(1));

    always_comb begin
        cls = C_UND;
        unique casez (opcode)
            8'h00:       cls = C_NOP;
            8'h01:       cls = C_HLT;
            8'h02:       cls = C_OUT;
            8'b00_010_???: cls = C_LDI;
            8'h18, 8'h19, 8'h1A: cls = C_JMP;
            8'h1B:       cls = C_CALL;
            8'h1C:       cls = C_RET;
            8'b01_??????: cls = C_MOV;
            8'b10_???_000: cls = C_ALU;
            default:     cls = C_UND;
        endcase
    end

    // Step index within the opcode-specific part of the sequence (cycle 2 is step 0).
    always_comb begin
        int step;
        cur  = S_NEXT;
        step = int'(cycle) - 2;
        if (cycle == CYCLE_W'(0)) begin
            cur = S_FETCH_PC;
        end else if (cycle == CYCLE_W'(1)) begin
            cur = S_FETCH_INST;
        end else begin
            case (cls)
                C_HLT: cur = S_HALT;
                C_OUT: begin
                    if (step == 0) cur = S_OUT_A;
                end
                C_LDI: begin
                    case (step)
                        0:       cur = S_FETCH_PC;
                        1:       cur = S_LDI;
                        default: cur = S_NEXT;
                    endcase
                end
                C_JMP: begin
                    case (step)
                        0:       cur = S_FETCH_PC;
                        1:       cur = S_JUMP;
                        default: cur = S_NEXT;
                    endcase
                end
                C_CALL: begin
                    case (step)
                        0:       cur = S_FETCH_PC;
                        1:       cur = S_TMP_STORE;
                        2:       cur = S_FETCH_SP;
                        3:       cur = S_PC_STORE;
                        4:       cur = S_TMP_JUMP;
                        default: cur = S_NEXT;
                    endcase
                end
                C_RET: begin
                    case (step)
                        0:       cur = S_INC_SP;
                        1:       cur = S_FETCH_SP;
                        2:       cur = S_RET;
                        default: cur = S_NEXT;
                    endcase
                end
                C_MOV: begin
                    case (step)
                        0:       cur = S_MOV_FETCH;
                        1:       cur = S_MOV_LOAD;
                        2:       cur = S_MOV_STORE;
                        default: cur = S_NEXT;
                    endcase
                end
                C_ALU: begin
                    if (step == 0) cur = S_ALU_OP;
                end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                C_UND:   cur = S_HALT;
`else
                C_UND:   cur = S_NEXT;
`endif
                default: cur = S_NEXT;
            endcase
        end
    end

    assign state = STATE_W'(cur);

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    assign illegal = past_fetch && (cls == C_UND);
`else
    assign illegal = 1'b0;
`endif

    // HALT freezes the counter; only reset_cycle or reset can leave it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
        end else if (reset_cycle) begin
            cycle <= '0;
        end else if (cur != S_HALT) begin
            cycle <= cycle + CYCLE_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed literal checks plus randomized run against a sequence-table model.
module tb_cpu_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] opcode;
    logic       rc_reg;
    logic       tie_rc;
    logic       reset_cycle;
    logic [3:0] cycle;
    logic [7:0] state;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    int m_cycle = 0;

    assign reset_cycle = tie_rc ? (state == 8'd0) : rc_reg;

    cpu_sequencer #(.STATE_W(8), .CYCLE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .reset_cycle(reset_cycle),
        .cycle(cycle), .state(state), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_defined(logic [7:0] op);
        return (op <= 8'h02) || (op[7:3] == 5'b00010) || (op >= 8'h18 && op <= 8'h1C) ||
               (op[7:6] == 2'b01) || (op[7:6] == 2'b10 && op[2:0] == 3'b000);
    endfunction

    // Each instruction is a list of states after FETCH_PC, FETCH_INST; past the list it reads NEXT.
    function automatic int exp_state(logic [7:0] op, int c);
        int seq[$];
        if (c == 0) return 1;
        if (c == 1) return 2;
        if (op == 8'h01) return 3;
        if (!is_defined(op)) begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            return 3;
`else
            return 0;
`endif
        end
        if (op == 8'h02) seq.push_back(5);
        else if (op[7:3] == 5'b00010) begin seq.push_back(1); seq.push_back(10); end
        else if (op >= 8'h18 && op <= 8'h1A) begin seq.push_back(1); seq.push_back(4); end
        else if (op == 8'h1B) begin
            seq.push_back(1); seq.push_back(11); seq.push_back(12);
            seq.push_back(13); seq.push_back(14);
        end
        else if (op == 8'h1C) begin seq.push_back(16); seq.push_back(12); seq.push_back(15); end
        else if (op[7:6] == 2'b01) begin seq.push_back(7); seq.push_back(8); seq.push_back(9); end
        else if (op[7:6] == 2'b10) seq.push_back(6);
        if (c - 2 < seq.size()) return seq[c-2];
        return 0;
    endfunction

    function automatic int exp_illegal(logic [7:0] op, int c);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        return (c >= 2 && !is_defined(op)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) m_cycle <= 0;
        else if (reset_cycle) m_cycle <= 0;
        else if (exp_state(opcode, m_cycle) != 3) m_cycle <= (m_cycle + 1) % 16;
    end

    always @(negedge clk) begin
        check("cmp_cycle", int'(cycle), m_cycle);
        check("cmp_state", int'(state), exp_state(opcode, m_cycle));
        check("cmp_illegal", int'(illegal), exp_illegal(opcode, m_cycle));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_seq(string nm, logic [7:0] op, input int seq[8], input int n);
        opcode = op;
        #1;
        for (int i = 0; i < n; i++) begin
            check(nm, int'(state), seq[i]);
            tick();
        end
    endtask

    int call_seq[8];
    int mov_seq[8];
    int alu_seq[8];
    logic [7:0] picks[12];

    initial begin
        call_seq = '{1, 2, 1, 11, 12, 13, 14, 0};
        mov_seq  = '{1, 2, 7, 8, 9, 0, 0, 0};
        alu_seq  = '{1, 2, 6, 0, 0, 0, 0, 0};
        picks    = '{8'h00, 8'h01, 8'h02, 8'h13, 8'h18, 8'h1A, 8'h1B, 8'h1C,
                     8'h4F, 8'h90, 8'hFF, 8'h05};
        reset = 1'b0; opcode = 8'h02; rc_reg = 1'b0; tie_rc = 1'b0;
        #1;
        check("rst_cycle", int'(cycle), 0);
        check("rst_state", int'(state), 1);
        tick(); tick();
        reset = 1'b1;

        // OUT, then async reset from cycle 5
        #1 check("out_c0", int'(state), 1);
        tick(); check("out_c1", int'(state), 2);
        tick(); check("out_c2", int'(state), 5);
        tick(); check("out_c3_state", int'(state), 0); check("out_c3_cycle", int'(cycle), 3);
        tick(); tick(); check("out_c5", int'(cycle), 5);
        reset = 1'b0;
        #1 check("async_cycle", int'(cycle), 0); check("async_state", int'(state), 1);
        tick(); reset = 1'b1;

        tie_rc = 1'b1;
        run_seq("call_seq", 8'h1B, call_seq, 8);
        check("call_restart", int'(cycle), 0);
        run_seq("mov_seq", 8'h4F, mov_seq, 6);
        run_seq("alu_seq", 8'h90, alu_seq, 4);
        check("alu_restart", int'(cycle), 0);

        opcode = 8'h01;
        tick(); tick();
        check("hlt_state", int'(state), 3);
        repeat (10) tick();
        check("hlt_cycle", int'(cycle), 2);
        check("hlt_hold", int'(state), 3);
        reset = 1'b0;
        #1 check("hlt_rst", int'(cycle), 0);
        tick(); reset = 1'b1;

        opcode = 8'hFF;
        tick(); tick();
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        check("und_state", int'(state), 3);
        check("und_illegal", int'(illegal), 1);
        repeat (3) tick();
        check("und_frozen", int'(cycle), 2);
`else
        check("und_state", int'(state), 0);
        check("und_illegal", int'(illegal), 0);
`endif
        tie_rc = 1'b0; rc_reg = 1'b1;
        tick(); rc_reg = 1'b0;
        check("rc_clear", int'(cycle), 0);

        opcode = 8'h1B;
        tick(); tick(); tick();
        check("call_c3", int'(state), 11);
        rc_reg = 1'b1;
        tick(); rc_reg = 1'b0;
        check("call_abort", int'(cycle), 0);

        opcode = 8'h00;
        repeat (15) tick();
        check("wrap_15", int'(cycle), 15);
        tick();
        check("wrap_0", int'(cycle), 0);

        for (int i = 0; i < 3000; i++) begin
            if (!reset) reset = 1'b1;
            else if ($urandom_range(99) == 0) reset = 1'b0;
            if (m_cycle < 2 && $urandom_range(1) == 0)
                opcode = ($urandom_range(3) == 0) ? 8'($urandom) : picks[$urandom_range(11)];
            tie_rc = ($urandom_range(7) != 0);
            rc_reg = ($urandom_range(15) == 0);
            tick();
        end
        reset = 1'b1; tie_rc = 1'b0; rc_reg = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
